// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the scoreboard hazard/forwarding controller
package hazard_pkg;

  localparam int LANE_W_MAX = 2;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    EX_MEM   = 2'd1,
    MEM_WB   = 2'd2,
    WB_BYP   = 2'd3
  } fwd_src_e;

  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_INTRA = 2'd2,
    ST_ORDER = 2'd3
  } stall_t;

  typedef struct packed {
    fwd_src_e                src;
    logic [LANE_W_MAX-1:0]   lane;
  } fwd_sel_t;

  typedef struct packed {
    logic                    valid;
    logic [1:0]              age;
    logic [LANE_W_MAX-1:0]   lane;
    logic                    is_load;
  } sb_entry_t;

  function automatic int lane_w(int issue_w);
    return (issue_w <= 2) ? 1 : $clog2(issue_w);
  endfunction

  // Age encoding matches the forwarding source encoding one-to-one.
  function automatic fwd_src_e slv2fwd_src(logic [1:0] v);
    return fwd_src_e'(v);
  endfunction

  function automatic stall_t slv2stall(logic [1:0] v);
    return stall_t'(v);
  endfunction

endpackage

// File: rtl/hazard_sb_lookup.sv
// rtl/hazard_sb_lookup.sv - per-operand scoreboard read: forwarding source and load-use hit
module hazard_sb_lookup
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2
) (
  input  sb_entry_t [NUM_REGS-1:0] sb_i,
  input  logic [4:0]               rs_i,
  output fwd_sel_t                 sel_o,
  output logic                     load_hit_o
);

  localparam logic [1:0] LL = 2'(LOAD_LAT);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  sb_entry_t e;

  always_comb begin
    e = '0;
    if (rs_i != 5'd0 && {1'b0, rs_i} < NR) e = sb_i[rs_i];
    sel_o.src  = e.valid ? slv2fwd_src(e.age) : FWD_NONE;
    sel_o.lane = e.valid ? e.lane : '0;
    load_hit_o = e.valid && e.is_load && (e.age < LL);
  end

endmodule

// File: rtl/hazard_sb_nw.sv
// rtl/hazard_sb_nw.sv - scoreboard hazard/forwarding controller for an in-order ISSUE_W-wide pipeline
module hazard_sb_nw
  import hazard_pkg::*;
#(
  parameter  int ISSUE_W     = 2,
  parameter  int NUM_REGS    = 32,
  parameter  int LOAD_LAT    = 2,
  parameter  int STALL_CNT_W = 16,
  localparam int LANE_W      = lane_w(ISSUE_W),
  localparam int FW          = 2 + LANE_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ex_ready_i,
  input  logic                           flush_i,
  input  logic [ISSUE_W-1:0]             id_valid_i,
  input  logic [ISSUE_W-1:0][4:0]        id_rs1_i,
  input  logic [ISSUE_W-1:0][4:0]        id_rs2_i,
  input  logic [ISSUE_W-1:0][4:0]        id_rd_i,
  input  logic [ISSUE_W-1:0]             id_regwr_i,
  input  logic [ISSUE_W-1:0]             id_isload_i,
  output logic [ISSUE_W-1:0]             issue_o,
  output logic                           id_hold_o,
  output logic [ISSUE_W-1:0][FW-1:0]     fwd_rs1_o,
  output logic [ISSUE_W-1:0][FW-1:0]     fwd_rs2_o,
  output logic [ISSUE_W-1:0][1:0]        stall_why_o,
  output logic [STALL_CNT_W-1:0]         stall_cnt_o
);

  localparam logic [5:0] NR = 6'(NUM_REGS);

  sb_entry_t [NUM_REGS-1:0] sb_q, sb_d;
  fwd_sel_t  [ISSUE_W-1:0]  sel1, sel2;
  logic      [ISSUE_W-1:0]  ld1, ld2;
  stall_t    [ISSUE_W-1:0]  why;
  logic      [ISSUE_W-1:0]  can_issue;
  logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    hazard_sb_lookup #(.NUM_REGS(NUM_REGS), .LOAD_LAT(LOAD_LAT)) u_rs1 (
      .sb_i(sb_q), .rs_i(id_rs1_i[k]), .sel_o(sel1[k]), .load_hit_o(ld1[k])
    );
    hazard_sb_lookup #(.NUM_REGS(NUM_REGS), .LOAD_LAT(LOAD_LAT)) u_rs2 (
      .sb_i(sb_q), .rs_i(id_rs2_i[k]), .sel_o(sel2[k]), .load_hit_o(ld2[k])
    );
  end

  // The first stalled valid lane blocks all younger lanes; invalid lanes never block.
  always_comb begin : p_hazard
    logic blocked;
    logic intra;
    blocked   = 1'b0;
    can_issue = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      why[k] = ST_NONE;
      intra  = 1'b0;
      for (int i = 0; i < k; i++) begin
        if (id_valid_i[i] && id_regwr_i[i] && id_rd_i[i] != 5'd0 &&
            (id_rd_i[i] == id_rs1_i[k] || id_rd_i[i] == id_rs2_i[k]))
          intra = 1'b1;
      end
      if (!id_valid_i[k]) begin
        why[k] = ST_NONE;
      end else if (blocked) begin
        why[k] = ST_ORDER;
      end else if (ld1[k] || ld2[k]) begin
        why[k]  = ST_LOAD;
        blocked = 1'b1;
      end else if (intra) begin
        why[k]  = ST_INTRA;
        blocked = 1'b1;
      end else begin
        can_issue[k] = 1'b1;
      end
    end
  end

  always_comb begin : p_outputs
    issue_o     = '0;
    id_hold_o   = 1'b0;
    stall_why_o = '0;
    fwd_rs1_o   = '0;
    fwd_rs2_o   = '0;
    if (rst_n) begin
      if (!flush_i) begin
        issue_o   = ex_ready_i ? can_issue : '0;
        id_hold_o = |(id_valid_i & ~issue_o);
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        stall_why_o[k] = why[k];
        fwd_rs1_o[k]   = {sel1[k].src, sel1[k].lane[LANE_W-1:0]};
        fwd_rs2_o[k]   = {sel2[k].src, sel2[k].lane[LANE_W-1:0]};
      end
    end
  end

  // Ascending lane order lets the youngest writer of a shared rd win.
  always_comb begin : p_sb_next
    sb_d = sb_q;
    if (ex_ready_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (sb_q[r].valid) begin
          if (sb_q[r].age == 2'd3) sb_d[r] = '0;
          else                     sb_d[r].age = sb_q[r].age + 2'd1;
        end
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        if (issue_o[k] && id_regwr_i[k] && id_rd_i[k] != 5'd0 && {1'b0, id_rd_i[k]} < NR)
          sb_d[id_rd_i[k]] = '{valid: 1'b1, age: 2'd1, lane: LANE_W_MAX'(k),
                               is_load: id_isload_i[k]};
      end
    end
    sb_d[0] = '0;
  end

  always_comb begin : p_cnt_next
    cnt_d = cnt_q;
    if (id_hold_o && ex_ready_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_sb_nw.sv
// tb/tb_hazard_sb_nw.sv - directed self-checking bench for hazard_sb_nw (4 lanes, 4-bit stall counter)
module tb_hazard_sb_nw;

  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n, ex_ready, flush;
  logic [IW-1:0]      id_valid, id_regwr, id_isload;
  logic [IW-1:0][4:0] id_rs1, id_rs2, id_rd;
  logic [IW-1:0]      issue;
  logic               id_hold;
  logic [IW-1:0][3:0] fwd_rs1, fwd_rs2;
  logic [IW-1:0][1:0] why;
  logic [3:0]         cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sb_nw #(.ISSUE_W(IW), .NUM_REGS(32), .LOAD_LAT(2), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_ready_i(ex_ready), .flush_i(flush),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_regwr_i(id_regwr), .id_isload_i(id_isload),
    .issue_o(issue), .id_hold_o(id_hold), .fwd_rs1_o(fwd_rs1), .fwd_rs2_o(fwd_rs2),
    .stall_why_o(why), .stall_cnt_o(cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_id();
    id_valid = '0; id_regwr = '0; id_isload = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
  endtask

  task automatic set_lane(input int k, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wr, input logic ld);
    id_valid[k] = v; id_rs1[k] = rs1; id_rs2[k] = rs2;
    id_rd[k] = rd; id_regwr[k] = wr; id_isload[k] = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    clear_id();
    set_lane(0, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    #2;
    check_eq("rst_issue", 32'(issue), 32'd0);
    check_eq("rst_hold", 32'(id_hold), 32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_fwd0", 32'(fwd_rs1[0]), 32'd0);
    check_eq("rst_why0", 32'(why[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_id();

    // ALU result forwarded at ages 1..3, then from the register file
    set_lane(0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    #2 check_eq("alu_issue", 32'(issue), 32'h1);
    tick(); clear_id();
    set_lane(0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    #2 check_eq("alu_age1", 32'(fwd_rs1[0]), 32'h4);
    tick(); #2 check_eq("alu_age2", 32'(fwd_rs1[0]), 32'h8);
    tick(); #2 check_eq("alu_age3", 32'(fwd_rs1[0]), 32'hC);
    tick(); #2 check_eq("alu_age4", 32'(fwd_rs1[0]), 32'h0);
    tick(); clear_id();

    // load-use stall, then forward from MEM_WB of lane 1
    set_lane(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    set_lane(1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    #2 check_eq("ld_issue", 32'(issue), 32'h3);
    tick(); clear_id();
    set_lane(0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    set_lane(1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    check_eq("lu_issue", 32'(issue), 32'h0);
    check_eq("lu_why0", 32'(why[0]), 32'd1);
    check_eq("lu_why1", 32'(why[1]), 32'd3);
    check_eq("lu_hold", 32'(id_hold), 32'd1);
    tick(); #2;
    check_eq("lu_issue2", 32'(issue), 32'h3);
    check_eq("lu_fwd", 32'(fwd_rs1[0]), 32'h9);
    check_eq("lu_cnt", 32'(cnt), 32'd1);
    check_eq("lu_hold2", 32'(id_hold), 32'd0);
    tick(); clear_id(); tick();

    // intra-bundle RAW
    set_lane(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    set_lane(1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    check_eq("raw_issue", 32'(issue), 32'h1);
    check_eq("raw_why1", 32'(why[1]), 32'd2);
    check_eq("raw_hold", 32'(id_hold), 32'd1);
    tick(); clear_id();
    set_lane(1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    check_eq("raw_issue2", 32'(issue), 32'h2);
    check_eq("raw_fwd", 32'(fwd_rs1[1]), 32'h4);
    tick(); clear_id(); tick(); tick();

    // WAW: youngest lane owns the entry; x0 never creates a dependency
    set_lane(1, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    set_lane(3, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    #2 check_eq("waw_issue", 32'(issue), 32'hA);
    tick(); clear_id();
    set_lane(0, 1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0);
    set_lane(1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    check_eq("waw_fwd", 32'(fwd_rs1[0]), 32'h7);
    check_eq("x0_issue", 32'(issue), 32'h3);
    tick(); clear_id();
    set_lane(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2 check_eq("x0_fwd", 32'(fwd_rs1[0]), 32'h0);
    tick(); clear_id(); tick(); tick(); tick();

    // backpressure holds ages; flush kills issue but ages still step
    set_lane(0, 1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
    #2 check_eq("bp_issue0", 32'(issue), 32'h1);
    tick(); clear_id();
    set_lane(0, 1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0);
    ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      check_eq("bp_issue", 32'(issue), 32'h0);
      check_eq("bp_fwd", 32'(fwd_rs1[0]), 32'h4);
      tick();
    end
    ex_ready = 1'b1;
    #2;
    check_eq("bp_fwd_after", 32'(fwd_rs1[0]), 32'h4);
    check_eq("bp_issue_after", 32'(issue), 32'h1);
    check_eq("bp_cnt", 32'(cnt), 32'd2);
    tick();
    flush = 1'b1;
    #2;
    check_eq("fl_issue", 32'(issue), 32'h0);
    check_eq("fl_hold", 32'(id_hold), 32'd0);
    check_eq("fl_fwd", 32'(fwd_rs1[0]), 32'h8);
    tick();
    flush = 1'b0;
    #2 check_eq("fl_aged", 32'(fwd_rs1[0]), 32'hC);
    tick(); clear_id();

    // persistent intra stall saturates the counter, then async reset mid-stall
    set_lane(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    set_lane(1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (20) tick();
    #2;
    check_eq("sat_cnt", 32'(cnt), 32'd15);
    check_eq("sat_hold", 32'(id_hold), 32'd1);
    check_eq("sat_fwd1", 32'(fwd_rs1[1]), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_issue", 32'(issue), 32'h0);
    check_eq("arst_hold", 32'(id_hold), 32'd0);
    check_eq("arst_cnt", 32'(cnt), 32'd0);
    check_eq("arst_fwd1", 32'(fwd_rs1[1]), 32'h0);
    check_eq("arst_why1", 32'(why[1]), 32'd0);
    clear_id();
    set_lane(0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    #2;
    check_eq("arst_sb_clear", 32'(fwd_rs1[0]), 32'h0);
    check_eq("arst_issue_after", 32'(issue), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
